// File: rtl/line_mem_pkg.sv
// Shared types and defaults for the line memory loader: FSM state encoding,
// parameter defaults and the words-per-line helper.
package line_mem_pkg;

  localparam int unsigned LineWDefault = 128;
  localparam int unsigned WordWDefault = 32;
  localparam int unsigned DepthDefault = 256;

  localparam int unsigned WORDS_PER_LINE = LineWDefault / WordWDefault;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone
  } state_e;

  function automatic int unsigned words_per_line(input int unsigned line_w,
                                                 input int unsigned word_w);
    return line_w / word_w;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line storage: one synchronous write port and one synchronous read port.
// A read and a write to the same line on the same edge return the old contents.
module line_mem_array #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_loader.sv
// Streams an instruction image into line-wide storage and serves word fetches.
// Optional per-word even parity is enabled by defining LINE_MEM_PARITY_EN.
module line_mem_loader
  import line_mem_pkg::*;
#(
  parameter int unsigned LINE_W = LineWDefault,
  parameter int unsigned WORD_W = WordWDefault,
  parameter int unsigned DEPTH  = DepthDefault
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WORD_W-1:0] ld_word,
  input  logic              ld_last,
  input  logic              rd_req,
  input  logic [31:0]       rd_addr,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              load_done,
  output logic              ld_overflow,
`ifdef LINE_MEM_PARITY_EN
  output logic              rd_perr,
`endif
  output logic              core_rst
);

  localparam int unsigned Wpl    = words_per_line(LINE_W, WORD_W);
  localparam int unsigned IdxW   = (Wpl > 1) ? $clog2(Wpl) : 1;
  localparam int unsigned AddrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LineLg = $clog2(LINE_W / 8);
  localparam int unsigned WordLg = $clog2(WORD_W / 8);
`ifdef LINE_MEM_PARITY_EN
  localparam int unsigned StoreW = LINE_W + Wpl;
`else
  localparam int unsigned StoreW = LINE_W;
`endif

  state_e            state_q;
  logic [AddrW-1:0]  ptr_q;
  logic [IdxW-1:0]   idx_q;
  logic [LINE_W-1:0] buf_q;
  logic              ld_ready_q;
  logic              load_done_q;
  logic              overflow_q;
  logic              rd_valid_q;
  logic [IdxW-1:0]   sel_q;

  logic              xfer;
  logic              line_full;
  logic              ptr_wrap;
  logic [LINE_W-1:0] merged;
  logic              wr_en;
  logic [LINE_W-1:0] wr_line;
  logic [StoreW-1:0] wr_store;
  logic [StoreW-1:0] rd_store;
  logic [LINE_W-1:0] rd_line;
  logic [AddrW-1:0]  rd_line_idx;
  logic [IdxW-1:0]   rd_sel;
  logic              unused_addr;

  // A word presented alongside ld_start is dropped with the abandoned load.
  assign xfer      = ld_valid && ld_ready_q && (state_q == StLoad) && !ld_start;
  assign line_full = (idx_q == IdxW'(Wpl - 1));
  assign ptr_wrap  = (ptr_q == AddrW'(DEPTH - 1));

  always_comb begin
    merged = buf_q;
    merged[idx_q*WORD_W +: WORD_W] = ld_word;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_line = merged;
    if (xfer && line_full) begin
      wr_en = 1'b1;
    end else if ((state_q == StFlush) && (idx_q != '0)) begin
      wr_en   = 1'b1;
      wr_line = buf_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      ld_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (ld_start) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            ld_ready_q  <= 1'b1;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        StLoad: begin
          if (ld_start) begin
            ptr_q      <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
            overflow_q <= 1'b0;
          end else if (xfer) begin
            if (line_full) begin
              ptr_q <= ptr_wrap ? '0 : ptr_q + 1'b1;
              idx_q <= '0;
              buf_q <= '0;
              if (ptr_wrap) begin
                overflow_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              buf_q <= merged;
            end
            if (ld_last) begin
              state_q    <= StFlush;
              ld_ready_q <= 1'b0;
            end
          end
        end
        StFlush: begin
          state_q     <= StDone;
          idx_q       <= '0;
          buf_q       <= '0;
          load_done_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Fetch address decode: byte offset within a word is ignored.
  assign rd_line_idx = rd_addr[LineLg +: AddrW];
  if (Wpl > 1) begin : g_sel
    assign rd_sel = rd_addr[WordLg +: IdxW];
  end else begin : g_nosel
    assign rd_sel = '0;
  end
  assign unused_addr = ^rd_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid_q <= 1'b0;
      sel_q      <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        sel_q <= rd_sel;
      end
    end
  end

`ifdef LINE_MEM_PARITY_EN
  logic [Wpl-1:0] wr_par;
  always_comb begin
    wr_par = '0;
    for (int k = 0; k < Wpl; k++) begin
      wr_par[k] = ^wr_line[k*WORD_W +: WORD_W];
    end
  end
  assign wr_store = {wr_par, wr_line};
  assign rd_perr  = rd_valid_q && ((^rd_data) != rd_store[LINE_W + sel_q]);
`else
  assign wr_store = wr_line;
`endif

  line_mem_array #(
    .DATA_W(StoreW),
    .DEPTH (DEPTH),
    .ADDR_W(AddrW)
  ) u_array (
    .clk_i  (CLK),
    .rst_i  (RST),
    .we_i   (wr_en),
    .waddr_i(ptr_q),
    .wdata_i(wr_store),
    .re_i   (rd_req),
    .raddr_i(rd_line_idx),
    .rdata_o(rd_store)
  );

  assign rd_line     = rd_store[LINE_W-1:0];
  assign rd_data     = rd_line[sel_q*WORD_W +: WORD_W];
  assign rd_valid    = rd_valid_q;
  assign ld_ready    = ld_ready_q;
  assign load_done   = load_done_q;
  assign ld_overflow = overflow_q;
  assign core_rst    = RST || !load_done_q;

endmodule

// File: tb/tb_line_mem_loader.sv
// Directed bench for line_mem_loader: a default instance and a DEPTH=4 instance
// for pointer wrap. Parity checks are built only when LINE_MEM_PARITY_EN is set.
module tb_line_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ld_start, ld_valid, ld_last, rd_req;
  logic [31:0] ld_word, rd_addr;
  logic [1:0]  ld_ready, rd_valid, load_done, ovf, core_rst;
  logic [31:0] rd_data0, rd_data1;
`ifdef LINE_MEM_PARITY_EN
  logic [1:0]  rd_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_mem_loader dut0 (
    .CLK        (clk),
    .RST        (rst),
    .ld_start   (ld_start[0]),
    .ld_valid   (ld_valid[0]),
    .ld_ready   (ld_ready[0]),
    .ld_word    (ld_word),
    .ld_last    (ld_last[0]),
    .rd_req     (rd_req[0]),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid[0]),
    .rd_data    (rd_data0),
    .load_done  (load_done[0]),
    .ld_overflow(ovf[0]),
`ifdef LINE_MEM_PARITY_EN
    .rd_perr    (rd_perr[0]),
`endif
    .core_rst   (core_rst[0])
  );

  line_mem_loader #(.DEPTH(4)) dut1 (
    .CLK        (clk),
    .RST        (rst),
    .ld_start   (ld_start[1]),
    .ld_valid   (ld_valid[1]),
    .ld_ready   (ld_ready[1]),
    .ld_word    (ld_word),
    .ld_last    (ld_last[1]),
    .rd_req     (rd_req[1]),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid[1]),
    .rd_data    (rd_data1),
    .load_done  (load_done[1]),
    .ld_overflow(ovf[1]),
`ifdef LINE_MEM_PARITY_EN
    .rd_perr    (rd_perr[1]),
`endif
    .core_rst   (core_rst[1])
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int d);
    ld_start[d] = 1'b1;
    tick();
    ld_start[d] = 1'b0;
  endtask

  task automatic send_word(input int d, input logic [31:0] w, input logic last);
    int n;
    n = 0;
    ld_valid[d] = 1'b1;
    ld_word     = w;
    ld_last[d]  = last;
    while (!ld_ready[d] && n < 16) begin
      tick();
      n++;
    end
    check_eq("ld_ready_before_xfer", 128'(ld_ready[d]), 128'd1);
    tick();
    ld_valid[d] = 1'b0;
    ld_last[d]  = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] addr, output logic [31:0] data);
    rd_req[d] = 1'b1;
    rd_addr   = addr;
    tick();
    rd_req[d] = 1'b0;
    check_eq("rd_valid", 128'(rd_valid[d]), 128'd1);
    data = (d == 0) ? rd_data0 : rd_data1;
  endtask

  task automatic fetch_line(input int d, input int line, output logic [127:0] l);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      fetch(d, 32'(line * 16 + k * 4), w);
      l[k*32 +: 32] = w;
    end
  endtask

  logic [31:0]  img [12] = '{32'h305a5073, 32'h00000073, 32'h00100073, 32'h000fffe7,
                             32'h0000006f, 32'h00010093, 32'h00018113, 32'h342021f3,
                             32'h34102ff3, 32'h004f8f93, 32'h341f9073, 32'h30200073};
  logic [127:0] line;
  logic [31:0]  word;

  initial begin
    rst = 1'b1;
    ld_start = '0; ld_valid = '0; ld_last = '0; rd_req = '0;
    ld_word = '0; rd_addr = '0;
    tick();
    tick();
    check_eq("rst_ld_ready", 128'(ld_ready), 128'd0);
    check_eq("rst_rd_valid", 128'(rd_valid), 128'd0);
    check_eq("rst_rd_data", 128'(rd_data0), 128'd0);
    check_eq("rst_load_done", 128'(load_done), 128'd0);
    check_eq("rst_overflow", 128'(ovf), 128'd0);
    check_eq("rst_core_rst", 128'(core_rst), 128'd3);
    rst = 1'b0;
    tick();
    check_eq("core_rst_before_load", 128'(core_rst[0]), 128'd1);

    // 12-word image, three full lines.
    start_load(0);
    for (int i = 0; i < 12; i++) send_word(0, img[i], i == 11);
    check_eq("flush_ready_low", 128'(ld_ready[0]), 128'd0);
    check_eq("flush_not_done", 128'(load_done[0]), 128'd0);
    tick();
    check_eq("done_after_flush", 128'(load_done[0]), 128'd1);
    check_eq("core_rst_released", 128'(core_rst[0]), 128'd0);
    fetch_line(0, 0, line);
    check_eq("img_line0", line, 128'h000fffe7_00100073_00000073_305a5073);
    fetch_line(0, 1, line);
    check_eq("img_line1", line, 128'h342021f3_00018113_00010093_0000006f);
    fetch_line(0, 2, line);
    check_eq("img_line2", line, 128'h30200073_341f9073_004f8f93_34102ff3);
    fetch(0, 32'h14, word);
    check_eq("fetch_0x14", 128'(word), 128'h00010093);
    fetch(0, 32'h15, word);
    check_eq("fetch_0x15", 128'(word), 128'h00010093);

    // ld_valid in DONE is ignored.
    ld_valid[0] = 1'b1; ld_word = 32'hdeadbeef; ld_last[0] = 1'b1;
    tick();
    tick();
    ld_valid[0] = 1'b0; ld_last[0] = 1'b0;
    check_eq("done_ready_low", 128'(ld_ready[0]), 128'd0);
    fetch_line(0, 2, line);
    check_eq("done_ignores_valid", line, 128'h30200073_341f9073_004f8f93_34102ff3);

    // 5 words: one full line plus a zero-filled partial.
    start_load(0);
    check_eq("restart_clears_done", 128'(load_done[0]), 128'd0);
    check_eq("restart_core_rst", 128'(core_rst[0]), 128'd1);
    for (int i = 1; i <= 5; i++) send_word(0, 32'(i), i == 5);
    check_eq("flush5_not_done", 128'(load_done[0]), 128'd0);
    tick();
    check_eq("flush5_one_cycle", 128'(load_done[0]), 128'd1);
    fetch_line(0, 0, line);
    check_eq("five_line0", line, 128'h00000004_00000003_00000002_00000001);
    fetch_line(0, 1, line);
    check_eq("five_line1", line, 128'h00000000_00000000_00000000_00000005);
    fetch_line(0, 2, line);
    check_eq("five_line2_kept", line, 128'h30200073_341f9073_004f8f93_34102ff3);

    // Reset mid-load discards the partial line.
    start_load(0);
    send_word(0, 32'ha, 1'b0);
    send_word(0, 32'hb, 1'b0);
    send_word(0, 32'hc, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_ready", 128'(ld_ready[0]), 128'd0);
    check_eq("midrst_done", 128'(load_done[0]), 128'd0);
    tick();
    check_eq("midrst_still_idle", 128'(ld_ready[0]), 128'd0);
    fetch_line(0, 0, line);
    check_eq("midrst_line0_kept", line, 128'h00000004_00000003_00000002_00000001);

    // Reload; the line-completing write coincides with a read of that line.
    start_load(0);
    send_word(0, 32'h11, 1'b0);
    send_word(0, 32'h12, 1'b0);
    send_word(0, 32'h13, 1'b0);
    rd_req[0] = 1'b1;
    rd_addr   = 32'h0;
    send_word(0, 32'h14, 1'b1);
    rd_req[0] = 1'b0;
    check_eq("rbw_valid", 128'(rd_valid[0]), 128'd1);
    check_eq("rbw_old_data", 128'(rd_data0), 128'h1);
    tick();
    check_eq("reload_done", 128'(load_done[0]), 128'd1);
    fetch_line(0, 0, line);
    check_eq("reload_line0", line, 128'h00000014_00000013_00000012_00000011);
    fetch_line(0, 1, line);
    check_eq("reload_line1_kept", line, 128'h00000000_00000000_00000000_00000005);

    // DEPTH=4 instance: 20 words wrap the pointer back onto line 0.
    start_load(1);
    for (int i = 1; i <= 20; i++) begin
      send_word(1, 32'(i), i == 20);
      if (i == 15) check_eq("ovf_before_wrap", 128'(ovf[1]), 128'd0);
      if (i == 16) check_eq("ovf_at_wrap", 128'(ovf[1]), 128'd1);
    end
    tick();
    check_eq("wrap_done", 128'(load_done[1]), 128'd1);
    check_eq("ovf_held", 128'(ovf[1]), 128'd1);
    fetch_line(1, 0, line);
    check_eq("wrap_line0", line, 128'h00000014_00000013_00000012_00000011);
    fetch_line(1, 1, line);
    check_eq("wrap_line1", line, 128'h00000008_00000007_00000006_00000005);
    check_eq("ovf_after_reads", 128'(ovf[1]), 128'd1);
    start_load(1);
    check_eq("ovf_cleared_by_start", 128'(ovf[1]), 128'd0);

`ifdef LINE_MEM_PARITY_EN
    dut0.u_array.mem_q[1][0] = ~dut0.u_array.mem_q[1][0];
    fetch(0, 32'h10, word);
    check_eq("perr_flipped", 128'(rd_perr[0]), 128'd1);
    fetch(0, 32'h14, word);
    check_eq("perr_clean", 128'(rd_perr[0]), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
